// File: rtl/instr_encoder.sv
// instr_encoder: turns an ARM instruction descriptor into a 32-bit ARM-state word
// (SWP, data processing imm/reg-shift-imm/reg-shift-reg, LDR imm offset, B/BL).
// Valid/ready on both sides; one descriptor in flight at a time.
// Data-processing immediates are found by a search for the smallest imm8/rotate pair
// that reproduces IMM32.
// Build option: define ENC_FAST_IMM_EN to check every rotation in the accept cycle
// instead of one rotation per clock. The IR and ERR values are identical in both builds.
module instr_encoder #(
    parameter int MAX_ROT   = 16,
    parameter bit ERR_ON_NV = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [2:0]  CLASS,
    input  logic [3:0]  COND,
    input  logic [3:0]  OPCODE,
    input  logic        S,
    input  logic        LINK,
    input  logic [3:0]  RD,
    input  logic [3:0]  RN,
    input  logic [3:0]  RM,
    input  logic [3:0]  RS,
    input  logic [1:0]  SHIFT_TYPE,
    input  logic [4:0]  SHIFT_AMT,
    input  logic [31:0] IMM32,
    input  logic [23:0] BR_OFFSET,
    output logic [31:0] IR,
    output logic        IR_VALID,
    input  logic        IR_READY,
    output logic        ERR
);

    localparam logic [2:0] CL_SWP   = 3'd0;
    localparam logic [2:0] CL_DPIMM = 3'd1;
    localparam logic [2:0] CL_RSI   = 3'd2;
    localparam logic [2:0] CL_RSR   = 3'd3;
    localparam logic [2:0] CL_LDR   = 3'd4;
    localparam logic [2:0] CL_B     = 3'd5;

    localparam logic [3:0] LAST_ROT = 4'(MAX_ROT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0]  cls;
        logic [3:0]  cond;
        logic [3:0]  opcode;
        logic        s;
        logic        link;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [3:0]  rs;
        logic [1:0]  shift_type;
        logic [4:0]  shift_amt;
        logic [31:0] imm32;
        logic [23:0] br_offset;
    } desc_t;

    state_t      state;
    desc_t       desc_in;
    desc_t       desc_q;
    logic [3:0]  cnt;
    logic [31:0] seq_rot;
    logic        seq_hit;

    // Rotate left by n bits (n < 32).
    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction

    // Descriptors that cannot be encoded regardless of the immediate search.
    function automatic logic desc_err(input desc_t d);
        logic e;
        e = 1'b0;
        if (d.cls > CL_B)
            e = 1'b1;
        if (ERR_ON_NV && (d.cond == 4'hF))
            e = 1'b1;
        if ((d.cls == CL_LDR) && (d.imm32[31:12] != 20'd0))
            e = 1'b1;
        return e;
    endfunction

    // Build the instruction word; rot/imm8 only matter for DP_IMM.
    function automatic logic [31:0] enc_word(input desc_t d, input logic [3:0] rot,
                                             input logic [7:0] imm8);
        logic [31:0] w;
        logic        cmp_op;
        logic        mov_op;
        logic        s_eff;
        logic [3:0]  rn_eff;
        logic [3:0]  rd_eff;
        // TST/TEQ/CMP/CMN only set flags; MOV/MVN have no first operand
        cmp_op = (d.opcode[3:2] == 2'b10);
        mov_op = (d.opcode == 4'hD) || (d.opcode == 4'hF);
        s_eff  = d.s | cmp_op;
        rd_eff = cmp_op ? 4'd0 : d.rd;
        rn_eff = mov_op ? 4'd0 : d.rn;
        w = 32'd0;
        case (d.cls)
            CL_SWP:   w = {d.cond, 8'b0001_0000, d.rn, d.rd, 4'b0000, 4'b1001, d.rm};
            CL_DPIMM: w = {d.cond, 3'b001, d.opcode, s_eff, rn_eff, rd_eff, rot, imm8};
            CL_RSI:   w = {d.cond, 3'b000, d.opcode, s_eff, rn_eff, rd_eff,
                           d.shift_amt, d.shift_type, 1'b0, d.rm};
            CL_RSR:   w = {d.cond, 3'b000, d.opcode, s_eff, rn_eff, rd_eff,
                           d.rs, 1'b0, d.shift_type, 1'b1, d.rm};
            CL_LDR:   w = {d.cond, 3'b010, 4'b1100, 1'b1, d.rn, d.rd, d.imm32[11:0]};
            CL_B:     w = {d.cond, 3'b101, d.link, d.br_offset};
            default:  w = 32'd0;
        endcase
        return w;
    endfunction

`ifdef ENC_FAST_IMM_EN
    logic [12:0] fast_res;

    // Result is {found, rot, imm8}; scanning downward lets the smallest rotation win.
    function automatic logic [12:0] fast_search(input logic [31:0] v);
        logic [12:0] res;
        logic [31:0] t;
        res = 13'd0;
        for (int r = MAX_ROT - 1; r >= 0; r--) begin
            t = rol32(v, 5'(2 * r));
            if (t[31:8] == 24'd0)
                res = {1'b1, 4'(r), t[7:0]};
        end
        return res;
    endfunction

    // Parallel immediate search on the live descriptor.
    always_comb begin
        fast_res = fast_search(IMM32);
    end
`endif

    // Gather the live descriptor fields into one bundle.
    always_comb begin
        desc_in            = '0;
        desc_in.cls        = CLASS;
        desc_in.cond       = COND;
        desc_in.opcode     = OPCODE;
        desc_in.s          = S;
        desc_in.link       = LINK;
        desc_in.rd         = RD;
        desc_in.rn         = RN;
        desc_in.rm         = RM;
        desc_in.rs         = RS;
        desc_in.shift_type = SHIFT_TYPE;
        desc_in.shift_amt  = SHIFT_AMT;
        desc_in.imm32      = IMM32;
        desc_in.br_offset  = BR_OFFSET;
    end

    // Rotation currently under test in SEARCH (r = cnt, rotate by 2r).
    always_comb begin
        seq_rot = rol32(desc_q.imm32, {cnt, 1'b0});
        seq_hit = (seq_rot[31:8] == 24'd0);
    end

    // Controller: accept, search, present the result and wait for the consumer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            REQ_READY <= 1'b1;
            IR        <= 32'd0;
            IR_VALID  <= 1'b0;
            ERR       <= 1'b0;
            cnt       <= 4'd0;
            desc_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (REQ_VALID) begin
                        desc_q    <= desc_in;
                        cnt       <= 4'd0;
                        REQ_READY <= 1'b0;
                        if (desc_err(desc_in)) begin
                            IR       <= 32'd0;
                            ERR      <= 1'b1;
                            IR_VALID <= 1'b1;
                            state    <= ST_OUT;
                        end else if (desc_in.cls == CL_DPIMM) begin
`ifdef ENC_FAST_IMM_EN
                            IR_VALID <= 1'b1;
                            state    <= ST_OUT;
                            if (fast_res[12]) begin
                                IR  <= enc_word(desc_in, fast_res[11:8], fast_res[7:0]);
                                ERR <= 1'b0;
                            end else begin
                                IR  <= 32'd0;
                                ERR <= 1'b1;
                            end
`else
                            state <= ST_SEARCH;
`endif
                        end else begin
                            IR       <= enc_word(desc_in, 4'd0, 8'd0);
                            ERR      <= 1'b0;
                            IR_VALID <= 1'b1;
                            state    <= ST_OUT;
                        end
                    end
                end
                ST_SEARCH: begin
                    if (seq_hit) begin
                        IR       <= enc_word(desc_q, cnt, seq_rot[7:0]);
                        ERR      <= 1'b0;
                        IR_VALID <= 1'b1;
                        state    <= ST_OUT;
                    end else if (cnt == LAST_ROT) begin
                        IR       <= 32'd0;
                        ERR      <= 1'b1;
                        IR_VALID <= 1'b1;
                        state    <= ST_OUT;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_OUT: begin
                    if (IR_READY) begin
                        IR        <= 32'd0;
                        ERR       <= 1'b0;
                        IR_VALID  <= 1'b0;
                        REQ_READY <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    IR_VALID  <= 1'b0;
                    REQ_READY <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
